// File: rtl/keypad_bcd_encoder_pkg.sv
// Shared types and widths for the debounced decimal keypad to BCD encoder.
package keypad_bcd_encoder_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned KEY_N = 10;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDebounce = 2'd1,
        StEmit     = 2'd2,
        StRelease  = 2'd3
    } state_e;

endpackage

// File: rtl/keypad_bcd_encoder_if.sv
// Code output handshake: producer drives bcd/multi/valid, consumer drives ready.
interface keypad_bcd_encoder_if;
    import keypad_bcd_encoder_pkg::*;

    logic [BCD_W-1:0] bcd;
    logic             valid;
    logic             multi;
    logic             ready;

    modport master (output bcd, output valid, output multi, input ready);
    modport slave  (input bcd, input valid, input multi, output ready);

endinterface

// File: rtl/dec10_to_bcd.sv
// Priority encoder (digit 9 wins) plus a more-than-one-key flag for a 10-bit key snapshot.
module dec10_to_bcd
    import keypad_bcd_encoder_pkg::*;
(
    input  logic [KEY_N-1:0] snap,
    output logic [BCD_W-1:0] code,
    output logic             multi
);

    logic [3:0] pop;

    // Ascending scan so the highest set bit is the last assignment to stick.
    always_comb begin
        code = '0;
        pop  = '0;
        for (int i = 0; i < KEY_N; i++) begin
            if (snap[i]) begin
                code = BCD_W'(i);
                pop  = pop + 4'd1;
            end
        end
    end

    assign multi = (pop > 4'd1);

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Synchronizes raw key lines, debounces press and release, and emits one BCD code per press.
module keypad_bcd_encoder
    import keypad_bcd_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_N-1:0]       key,
    output logic                   busy,
    keypad_bcd_encoder_if.master   kbus
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_N-1:0] key_meta_q, skey_q;
    logic [KEY_N-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             multi_q, multi_d;
    logic             valid_q, valid_d;
    state_e           state_q, state_d;

    logic [BCD_W-1:0] dec_code;
    logic             dec_multi;

    dec10_to_bcd u_dec (
        .snap  (snap_q),
        .code  (dec_code),
        .multi (dec_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= '0;
            skey_q     <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            multi_q    <= 1'b0;
            valid_q    <= 1'b0;
            state_q    <= StIdle;
        end else begin
            key_meta_q <= key;
            skey_q     <= key_meta_q;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            multi_q    <= multi_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        multi_d = multi_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (skey_q != '0) begin
                    state_d = StDebounce;
                    snap_d  = skey_q;
                    cnt_d   = '0;
                end
            end
            StDebounce: begin
                if (skey_q != snap_q) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StEmit;
                    bcd_d   = dec_code;
                    multi_d = dec_multi;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEmit: begin
                // Outputs are frozen here regardless of key activity until the consumer takes them.
                if (kbus.ready) begin
                    valid_d = 1'b0;
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (skey_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign kbus.bcd   = bcd_q;
    assign kbus.multi = multi_q;
    assign kbus.valid = valid_q;
    assign busy       = (state_q != StIdle);

endmodule
